// File: rtl/net_force_pkg.sv
// Shared types for the net force/release controller.
// Command opcodes and the release-all sweep FSM states.
package net_force_pkg;

    typedef enum logic [1:0] {
        OP_FORCE       = 2'd0,
        OP_FORCE_TIMED = 2'd1,
        OP_RELEASE     = 2'd2,
        OP_RELEASE_ALL = 2'd3
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/net_force_chan.sv
// One channel: force mask/value, auto-release timer and output mux.
// A set or release aimed here wins over a timer expiring on the same edge.
module net_force_chan #(
    parameter int W     = 8,
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     drv,
    input  logic             set_en,
    input  logic             set_timed,
    input  logic [W-1:0]     set_mask,
    input  logic [W-1:0]     set_value,
    input  logic [DUR_W-1:0] set_dur,
    input  logic             rel_en,
    input  logic [W-1:0]     rel_mask,
    input  logic             clr_en,
    output logic [W-1:0]     net,
    output logic             active
);

    logic [W-1:0]     fmask;
    logic [W-1:0]     fval;
    logic [DUR_W-1:0] timer;
    logic             timed;
    logic [W-1:0]     kept;
    logic             expire;

    // Mask surviving a release, and whether the timer runs out this edge
    always_comb begin
        kept   = rel_en ? (fmask & ~rel_mask) : fmask;
        expire = timed && (timer == DUR_W'(1));
    end

    // Per-channel force state; sweep clear beats commands beats expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            fmask <= '0;
            fval  <= '0;
            timer <= '0;
            timed <= 1'b0;
        end else if (clr_en) begin
            fmask <= '0;
            timer <= '0;
            timed <= 1'b0;
        end else if (set_en) begin
            fmask <= fmask | set_mask;
            fval  <= (fval & ~set_mask) | (set_value & set_mask);
            timer <= set_timed ? set_dur : '0;
            timed <= set_timed;
        end else if (rel_en && (kept == '0)) begin
            fmask <= '0;
            timer <= '0;
            timed <= 1'b0;
        end else if (expire) begin
            // a partial release on the expiry edge keeps its survivors
            fmask <= rel_en ? kept : '0;
            timer <= '0;
            timed <= 1'b0;
        end else begin
            fmask <= kept;
            if (timed) begin
                timer <= timer - DUR_W'(1);
            end
        end
    end

    // Forced bits override the live driver value
    always_comb begin
        net    = (drv & ~fmask) | (fval & fmask);
        active = |fmask;
    end

endmodule

// File: rtl/net_force_ctrl.sv
// Multi-channel force/release controller for observed nets.
// Decodes commands, runs the release-all sweep and flags bad channels.
module net_force_ctrl
    import net_force_pkg::*;
#(
    parameter  int CH    = 4,
    parameter  int W     = 8,
    parameter  int DUR_W = 8,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*W-1:0]   drv_in,
    output logic [CH*W-1:0]   net_out,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [W-1:0]      cmd_mask,
    input  logic [W-1:0]      cmd_value,
    input  logic [DUR_W-1:0]  cmd_dur,
    output logic [CH-1:0]     force_active,
    output logic              cmd_err
);

    cmd_op_e         op;
    state_e          state;
    logic [CH_W-1:0] sweep_idx;
    logic            accept;
    logic            is_rel_all;
    logic            ch_ok;
    logic            chan_cmd;
    logic            do_set;
    logic            set_timed;
    logic            do_rel;

    // Command decode; a zero-length timed force is a silent no-op
    always_comb begin
        op         = cmd_op_e'(cmd_op);
        accept     = cmd_valid && cmd_ready;
        is_rel_all = (op == OP_RELEASE_ALL);
        ch_ok      = int'(cmd_ch) < CH;
        chan_cmd   = accept && !is_rel_all && ch_ok;
        set_timed  = (op == OP_FORCE_TIMED);
        do_set     = chan_cmd &&
                     ((op == OP_FORCE) ||
                      (set_timed && (cmd_dur != '0)));
        do_rel     = chan_cmd && (op == OP_RELEASE);
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic hit;
        logic clr;

        assign hit = (int'(cmd_ch) == c);
        assign clr = (state == ST_SWEEP) && (int'(sweep_idx) == c);

        net_force_chan #(
            .W     (W),
            .DUR_W (DUR_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .drv       (drv_in[c*W +: W]),
            .set_en    (do_set && hit),
            .set_timed (set_timed),
            .set_mask  (cmd_mask),
            .set_value (cmd_value),
            .set_dur   (cmd_dur),
            .rel_en    (do_rel && hit),
            .rel_mask  (cmd_mask),
            .clr_en    (clr),
            .net       (net_out[c*W +: W]),
            .active    (force_active[c])
        );
    end

    // Sweep FSM: one channel cleared per cycle, ready held low meanwhile
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
            cmd_ready <= 1'b1;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= accept && !is_rel_all && !ch_ok;
            unique case (state)
                ST_IDLE: begin
                    if (accept && is_rel_all) begin
                        state     <= ST_SWEEP;
                        sweep_idx <= '0;
                        cmd_ready <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (int'(sweep_idx) == CH - 1) begin
                        state     <= ST_IDLE;
                        sweep_idx <= '0;
                        cmd_ready <= 1'b1;
                    end else begin
                        sweep_idx <= sweep_idx + CH_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    sweep_idx <= '0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_net_force_ctrl.sv
// Bench for net_force_ctrl: directed scenarios plus random commands.
// Five channels so that an out-of-range channel index is encodable.
module tb_net_force_ctrl;

    localparam int CH    = 5;
    localparam int W     = 8;
    localparam int DUR_W = 8;
    localparam int CH_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*W-1:0]   drv_in;
    logic [CH*W-1:0]   net_out;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [CH_W-1:0]   cmd_ch;
    logic [W-1:0]      cmd_mask;
    logic [W-1:0]      cmd_value;
    logic [DUR_W-1:0]  cmd_dur;
    logic [CH-1:0]     force_active;
    logic              cmd_err;

    net_force_ctrl #(
        .CH    (CH),
        .W     (W),
        .DUR_W (DUR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .drv_in       (drv_in),
        .net_out      (net_out),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_ch       (cmd_ch),
        .cmd_mask     (cmd_mask),
        .cmd_value    (cmd_value),
        .cmd_dur      (cmd_dur),
        .force_active (force_active),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH*W-1:0] net;
        logic [CH-1:0]   act;
        logic            rdy;
        logic            err;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 0;

    // reference model state
    logic [W-1:0] m_fmask [CH];
    logic [W-1:0] m_fval  [CH];
    int           m_timer [CH];
    bit           m_timed [CH];
    bit           m_sweep;
    int           m_pos;
    bit           m_ready;
    bit           m_err;

    function automatic obs_t model_out(logic [CH*W-1:0] drv);
        obs_t o;
        for (int c = 0; c < CH; c++) begin
            o.net[c*W +: W] = (drv[c*W +: W] & ~m_fmask[c]) |
                              (m_fval[c] & m_fmask[c]);
            o.act[c] = (m_fmask[c] != 0);
        end
        o.rdy = m_ready;
        o.err = m_err;
        return o;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_fmask[c] = '0;
            m_fval[c]  = '0;
            m_timer[c] = 0;
            m_timed[c] = 0;
        end
        m_sweep = 0;
        m_pos   = 0;
        m_ready = 1;
        m_err   = 0;
    endtask

    task automatic model_edge(bit r, bit v, int op, int ch,
                              logic [W-1:0] mask, logic [W-1:0] value,
                              int dur);
        bit acc;
        logic [W-1:0] nm;
        if (r) begin
            model_reset();
            return;
        end
        acc = v && m_ready;
        for (int c = 0; c < CH; c++) begin
            if (m_sweep && m_pos == c) begin
                m_fmask[c] = '0;
                m_timed[c] = 0;
                m_timer[c] = 0;
            end else if (acc && op != 3 && ch == c &&
                         !(op == 1 && dur == 0)) begin
                if (op == 2) begin
                    nm = m_fmask[c] & ~mask;
                    m_fmask[c] = nm;
                    if (nm == 0) begin
                        m_timed[c] = 0;
                        m_timer[c] = 0;
                    end else if (m_timed[c]) begin
                        m_timer[c]--;
                        if (m_timer[c] == 0) m_timed[c] = 0;
                    end
                end else begin
                    m_fmask[c] = m_fmask[c] | mask;
                    m_fval[c]  = (m_fval[c] & ~mask) | (value & mask);
                    m_timed[c] = (op == 1);
                    m_timer[c] = (op == 1) ? dur : 0;
                end
            end else if (m_timed[c]) begin
                m_timer[c]--;
                if (m_timer[c] == 0) begin
                    m_timed[c] = 0;
                    m_fmask[c] = '0;
                end
            end
        end
        m_err = acc && op != 3 && ch >= CH;
        if (m_sweep) begin
            m_pos++;
            if (m_pos == CH) begin
                m_sweep = 0;
                m_ready = 1;
            end
        end else if (acc && op == 3) begin
            m_sweep = 1;
            m_pos   = 0;
            m_ready = 0;
        end
    endtask

    // One clock cycle: drive, queue expected outputs, advance the model
    task automatic step(bit r, bit v, int op, int ch,
                        logic [W-1:0] mask, logic [W-1:0] value,
                        int dur, logic [CH*W-1:0] drv);
        @(negedge clk);
        rst       = r;
        drv_in    = drv;
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_ch    = CH_W'(ch);
        cmd_mask  = mask;
        cmd_value = value;
        cmd_dur   = DUR_W'(dur);
        #1;
        if (started) exp_q.push_back(model_out(drv));
        @(posedge clk);
        model_edge(r, v, op, ch, mask, value, dur);
    endtask

    task automatic idle(logic [CH*W-1:0] drv);
        step(0, 0, 0, 0, '0, '0, 0, drv);
    endtask

    task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard monitor: compare every queued expectation mid-cycle
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {net_out, force_active, cmd_ready, cmd_err};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL obs t=%0t got=%h want=%h", $time, a, e);
                end
            end
        end
    end

    initial begin
        logic [CH*W-1:0] d;
        logic [63:0]     r64;
        int              n;
        int              op;
        rst = 1; drv_in = '0; cmd_valid = 0; cmd_op = '0; cmd_ch = '0;
        cmd_mask = '0; cmd_value = '0; cmd_dur = '0;
        model_reset();
        step(1, 0, 0, 0, '0, '0, 0, '0);
        step(1, 0, 0, 0, '0, '0, 0, '0);
        started = 1;

        d = '0;
        d[0*W +: W] = 8'h3c;
        idle(d);
        #1;
        chk("reset_net0", net_out[0 +: W], 8'h3c);
        chk("reset_active", W'(force_active), 8'h00);
        chk("reset_ready", W'(cmd_ready), 8'h01);

        step(0, 1, 0, 1, 8'hff, 8'h5f, 0, d);
        #1;
        chk("force_ch1", net_out[1*W +: W], 8'h5f);
        d[1*W +: W] = 8'h99;
        idle(d);
        #1;
        chk("force_ch1_drv", net_out[1*W +: W], 8'h5f);
        step(0, 1, 0, 1, 8'h0f, 8'h05, 0, d);
        #1;
        chk("force_ch1_part", net_out[1*W +: W], 8'h55);

        d[0*W +: W] = 8'h00;
        step(0, 1, 1, 0, 8'h01, 8'h01, 3, d);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("timed_ch0_%0d", i), net_out[0 +: W],
                (i < 3) ? 8'h01 : 8'h00);
            idle(d);
        end

        step(0, 1, 0, 0, 8'hff, 8'haa, 0, d);
        step(0, 1, 0, 2, 8'hff, 8'h33, 0, d);
        step(0, 1, 3, 0, '0, '0, 0, d);
        n = 0;
        #1;
        while (cmd_ready == 1'b0 && n < 20) begin
            n++;
            idle(d);
            #1;
        end
        chk("sweep_ready_low", W'(n), W'(CH));
        chk("sweep_active", W'(force_active), 8'h00);

        step(0, 1, 1, 3, 8'hff, 8'h11, 2, d);
        idle(d);
        step(0, 1, 0, 3, 8'hff, 8'ha5, 0, d);
        for (int i = 0; i < 4; i++) idle(d);
        #1;
        chk("expiry_race_ch3", net_out[3*W +: W], 8'ha5);

        step(0, 1, 0, 5, 8'hff, 8'h77, 0, d);
        #1;
        chk("illegal_err", W'(cmd_err), 8'h01);
        idle(d);
        #1;
        chk("illegal_err_pulse", W'(cmd_err), 8'h00);
        step(0, 1, 1, 4, 8'hff, 8'h77, 0, d);
        #1;
        chk("dur0_err", W'(cmd_err), 8'h00);
        chk("dur0_net4", net_out[4*W +: W], d[4*W +: W]);

        step(0, 1, 0, 4, 8'hf0, 8'h80, 0, d);
        step(0, 1, 3, 0, '0, '0, 0, d);
        idle(d);
        step(1, 0, 0, 0, '0, '0, 0, d);
        idle(d);
        #1;
        chk("midsweep_rst_rdy", W'(cmd_ready), 8'h01);

        for (int i = 0; i < 500; i++) begin
            r64 = {$urandom(), $urandom()};
            op  = int'($urandom_range(0, 9));
            op  = (op < 4) ? 0 : (op < 7) ? 1 : (op < 9) ? 2 : 3;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 op, int'($urandom_range(0, 6)), W'($urandom()),
                 W'($urandom()), int'($urandom_range(0, 6)),
                 r64[CH*W-1:0]);
        end

        idle(d);
        idle(d);
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #3;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
